alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Arbiter that lets two requesters share the single combinational MIPS ALU: pipeline EX stage (requester 0) and branch/auxiliary unit (requester 1). It selects one request per cycle, drives the ALU's instruction/operand inputs, captures `result`/`flags` into a one-entry response register, and returns them with a valid/ready handshake tagged by requester. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

## Interface
- `DATA_W`, 32, operand/result width; only 32 is supported.
- `FLAG_W`, 3, ALU flag width: [2] zero, [1] negative, [0] overflow.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; discards buffered response and blocks grants this cycle.
- `req_valid`  in  2  bit i = requester i presents a request.
- `req_ready`  out  2  one-hot grant; request i is accepted in a cycle where `req_valid[i] & req_ready[i]`.
- `req0_instr`, `req0_a`, `req0_b`  in  32 each  requester 0 instruction, regA, regB.
- `req1_instr`, `req1_a`, `req1_b`  in  32 each  requester 1 instruction, regA, regB.
- `alu_instr`, `alu_a`, `alu_b`  out  32 each  to ALU; granted requester's fields, all-zero when no grant.
- `alu_result`  in  32  from ALU.
- `alu_flags`  in  3  from ALU.
- `rsp_valid`  out  2  one-hot; bit i = buffered response belongs to requester i.
- `rsp_result`  out  32  buffered result.
- `rsp_flags`  out  3  buffered flags.
- `rsp_ready`  in  2  bit i = requester i accepts the response this cycle.

## Operation
- Response buffer state: EMPTY or FULL (plus 1-bit owner id). `rsp_valid` = FULL ? one-hot(owner) : 0.
- Drain: FULL and `rsp_ready[owner]` -> response consumed this cycle. `rsp_ready` of the non-owner is ignored.
- Grant allowed when `!flush` and (EMPTY or draining). `req_ready` is combinational from `req_valid`, state, `rsp_ready`, priority pointer.
- Arbitration: round-robin. Only one valid -> grant it. Both valid -> grant the requester not granted most recently. Pointer `last` updates only on an actual grant.
- On grant to i: `alu_*` = requester i fields; at the edge, buffer <= {`alu_result`, `alu_flags`}, owner <= i, state FULL.
- No grant and draining -> EMPTY. No grant, not draining -> hold (result/flags/owner stable).
- Grant and drain in the same cycle -> stays FULL with new data (back-to-back, 1 op/cycle).
- `flush`: at the edge state <= EMPTY regardless of drain; `req_ready` = 0 that cycle; pointer unchanged.
- Flags and result are passed through unmodified; no interpretation of opcode.
- `reset` (any time, including mid-response): state EMPTY, `last` = 1 (requester 0 wins first contention), buffer data cleared to 0. Outputs after reset: `req_ready` follows grant logic (not forced 0), `rsp_valid` = 0, `rsp_result` = 0, `rsp_flags` = 0, `alu_*` = 0 until a request is valid.

## Timing
- Accept-to-response latency: 1 cycle (grant in cycle N, `rsp_valid` high from cycle N+1).
- Throughput: 1 op/cycle when owner keeps `rsp_ready` high.
- Backpressure: `rsp_ready[owner]` low -> `req_ready` = 0 for both until drain.
- Requester must hold `req_valid` and fields stable until accepted; arbiter does not latch them.
- ALU path is combinational within the grant cycle; single-cycle path req mux -> ALU -> buffer.
- Contention: with both valid continuously and no backpressure, grants alternate 0,1,0,1...

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`: defined -> fixed priority, requester 0 always wins contention; pointer unused. Requester 1 can starve; accepted by design for EX-critical builds.
- Undefined (default) -> round-robin as above.

## Test plan
- Single request: req0 valid, instr `add`, a=5, b=7, `rsp_ready`=11 -> `req_ready`=01 in cycle N, `rsp_valid`=01, `rsp_result`=12, `rsp_flags`=000 in N+1.
- Contention: both valid continuously for 4 cycles after reset, ready=11 -> grants 0,1,0,1; `rsp_valid` 01,10,01,10 one cycle later (with `ALU_ARB_FIXED_PRIO_EN`: 0,0,0,0).
- Backpressure: req1 `sub` 0x80000000-1 granted, `rsp_ready[1]`=0 for 3 cycles -> `rsp_result`=0x7FFFFFFF, flags=001 held, `req_ready`=00; on ready, drain and new grant same cycle.
- Non-owner ready: response owned by 0, `rsp_ready`=10 -> buffer held, no grant.
- Flush while FULL and req0 valid -> `req_ready`=00, next cycle `rsp_valid`=00; following cycle req0 granted.
- Async reset asserted mid-cycle while FULL -> `rsp_valid`=00, `rsp_result`=0 immediately; after release, contention grants requester 0 first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Lets two requesters share one combinational MIPS ALU. Requester 0 is the
// pipeline EX stage, requester 1 the branch/auxiliary unit. One request is
// granted per cycle. The granted request's instruction and operands are driven
// to the ALU. The ALU result and flags are captured into a one-entry response
// buffer, which is returned with a valid/ready handshake tagged by requester.
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins contention
//                          undefined -> round-robin (default)
//
// Ports:
//   clk                      single clock, rising edge
//   reset                    asynchronous active-high reset
//   flush                    drops the buffered response, blocks grants this cycle
//   req_valid[1:0]           request present, bit i = requester i
//   req_ready[1:0]           one-hot grant (combinational)
//   req0_instr/a/b           requester 0 instruction and operands
//   req1_instr/a/b           requester 1 instruction and operands
//   alu_instr/a/b            to ALU; granted fields, zero when no grant
//   alu_result, alu_flags    from ALU (flags: [2] zero, [1] negative, [0] ovf)
//   rsp_valid[1:0]           one-hot owner of the buffered response
//   rsp_result, rsp_flags    buffered response
//   rsp_ready[1:0]           requester i accepts the response
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int DATA_W = 32,
   parameter int FLAG_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req0_instr,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [DATA_W-1:0] req1_instr,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic [DATA_W-1:0] alu_instr,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [FLAG_W-1:0] alu_flags,
   output logic [1:0]        rsp_valid,
   output logic [DATA_W-1:0] rsp_result,
   output logic [FLAG_W-1:0] rsp_flags,
   input  logic [1:0]        rsp_ready
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state_reg;
   logic              owner_reg;
   logic [DATA_W-1:0] result_reg;
   logic [FLAG_W-1:0] flags_reg;
`ifndef ALU_ARB_FIXED_PRIO_EN
   // Index of the requester granted most recently; reset to 1 so that
   // requester 0 wins the first contention.
   logic              last_reg;
`endif

   logic drain;
   logic grant_ok;
   logic grant_any;
   logic grant_idx;

   // Buffer drains only on the owner's ready; the other bit is ignored.
   // A slot is available when empty or when the current response leaves
   // this cycle, which gives back-to-back operation at one op per cycle.
   always_comb begin
      drain     = (state_reg == FULL) && rsp_ready[owner_reg];
      grant_ok  = !flush && ((state_reg == EMPTY) || drain);
      grant_any = grant_ok && (req_valid != 2'b00);
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_idx = !req_valid[0];
`else
      if (req_valid == 2'b11) begin
         grant_idx = !last_reg;
      end else begin
         grant_idx = !req_valid[0];
      end
`endif
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_onehot
         assign req_ready[gi] = grant_any && (grant_idx == 1'(gi));
         assign rsp_valid[gi] = (state_reg == FULL) && (owner_reg == 1'(gi));
      end
   endgenerate

   // The ALU sees zeros unless a grant is actually issued this cycle.
   always_comb begin
      alu_instr = '0;
      alu_a     = '0;
      alu_b     = '0;
      if (grant_any) begin
         if (grant_idx) begin
            alu_instr = req1_instr;
            alu_a     = req1_a;
            alu_b     = req1_b;
         end else begin
            alu_instr = req0_instr;
            alu_a     = req0_a;
            alu_b     = req0_b;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= EMPTY;
         owner_reg  <= 1'b0;
         result_reg <= '0;
         flags_reg  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_reg   <= 1'b1;
`endif
      end else begin
         if (flush) begin
            // Response discarded even if it was being drained.
            state_reg <= EMPTY;
         end else if (grant_any) begin
            state_reg  <= FULL;
            owner_reg  <= grant_idx;
            result_reg <= alu_result;
            flags_reg  <= alu_flags;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_reg   <= grant_idx;
`endif
         end else if (drain) begin
            state_reg <= EMPTY;
         end
      end
   end

   assign rsp_result = result_reg;
   assign rsp_flags  = flags_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Self-checking bench for alu_share_arbiter. A small behavioural ALU sits on
// the ALU ports. The driver predicts each grant from the arbitration rules and
// pushes the expected response into a queue; the monitor compares the buffered
// response against the queue head every cycle and pops it on handshake.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req0_instr, req0_a, req0_b;
   logic [31:0] req1_instr, req1_a, req1_b;
   logic [31:0] alu_instr, alu_a, alu_b;
   logic [31:0] alu_result;
   logic [2:0]  alu_flags;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_result;
   logic [2:0]  rsp_flags;
   logic [1:0]  rsp_ready;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        owner;
      logic [31:0] res;
      logic [2:0]  fl;
   } rsp_t;

   rsp_t exp_q[$];
   logic model_last;

   localparam logic [31:0] OP_ADD = 32'd0;
   localparam logic [31:0] OP_SUB = 32'd1;

   alu_share_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req0_instr (req0_instr),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_instr (req1_instr),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .alu_instr  (alu_instr),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_flags  (alu_flags),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .rsp_ready  (rsp_ready)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: returns {result, zero, negative, overflow}.
   function automatic logic [34:0] ref_alu(input logic [31:0] instr,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      logic        ovf;
      r   = a;
      ovf = 1'b0;
      case (instr[3:0])
         4'd0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
         4'd1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = {31'd0, ($signed(a) < $signed(b))};
         default: r = a;
      endcase
      return {r, (r == 32'd0), r[31], ovf};
   endfunction

   always_comb {alu_result, alu_flags} = ref_alu(alu_instr, alu_a, alu_b);

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [31:0] rnd_instr();
      return ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 6));
   endfunction

   // One clock of stimulus: drive at the falling edge, check the combinational
   // grant and ALU drive against the arbitration rules, then update the model.
   task automatic cycle(input logic [1:0] v,
                        input logic [31:0] i0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] i1, input logic [31:0] a1, input logic [31:0] b1,
                        input logic [1:0] rr, input logic fl,
                        output logic [1:0] granted);
      logic        full, drain, can, idx;
      logic [34:0] r;
      logic [95:0] fexp;
      rsp_t        nxt;
      @(negedge clk);
      req_valid  = v;
      req0_instr = i0; req0_a = a0; req0_b = b0;
      req1_instr = i1; req1_a = a1; req1_b = b1;
      rsp_ready  = rr;
      flush      = fl;
      #1;
      full  = (exp_q.size() != 0);
      drain = full ? rr[exp_q[0].owner] : 1'b0;
      can   = !fl && (!full || drain) && (v != 2'b00);
`ifdef ALU_ARB_FIXED_PRIO_EN
      idx = !v[0];
`else
      idx = (v == 2'b11) ? !model_last : !v[0];
`endif
      granted = can ? (idx ? 2'b10 : 2'b01) : 2'b00;
      check("req_ready", 128'(req_ready), 128'(granted));
      fexp = !can ? 96'd0 : (idx ? {i1, a1, b1} : {i0, a0, b0});
      check("alu_drive", 128'({alu_instr, alu_a, alu_b}), 128'(fexp));
      r = idx ? ref_alu(i1, a1, b1) : ref_alu(i0, a0, b0);
      @(posedge clk);
      #1;
      if (fl) exp_q.delete();
      if (can) begin
         nxt.owner = idx;
         nxt.res   = r[34:3];
         nxt.fl    = r[2:0];
         exp_q.push_back(nxt);
         model_last = idx;
      end
   endtask

   // Monitor: compares the presented response with the queue head and pops
   // it when the owner takes it.
   always @(negedge clk) begin : monitor
      rsp_t e;
      #2;
      if (exp_q.size() == 0) begin
         check("rsp_idle", 128'(rsp_valid), 128'd0);
      end else begin
         e = exp_q[0];
         check("rsp", 128'({rsp_valid, rsp_result, rsp_flags}),
               128'({(e.owner ? 2'b10 : 2'b01), e.res, e.fl}));
         if (rsp_ready[e.owner]) begin
            $display("rsp owner=%0d result=%h flags=%b", e.owner, rsp_result, rsp_flags);
            void'(exp_q.pop_front());
         end
      end
   end

   logic [1:0]  g;
   logic [1:0]  pv;
   logic [31:0] pi [2];
   logic [31:0] pa [2];
   logic [31:0] pb [2];
   logic [1:0]  cont_exp [4];

   initial begin
      reset = 1'b1; flush = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
      req0_instr = 0; req0_a = 0; req0_b = 0;
      req1_instr = 0; req1_a = 0; req1_b = 0;
      model_last = 1'b1;
      @(negedge clk);
      check("reset_state", 128'({rsp_valid, rsp_result, rsp_flags, req_ready, alu_instr}), 128'd0);
      @(negedge clk);
      #3 reset = 1'b0;

      // Contention right after reset.
`ifdef ALU_ARB_FIXED_PRIO_EN
      cont_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      cont_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
      for (int k = 0; k < 4; k++) begin
         cycle(2'b11, OP_ADD, 32'd1, 32'd2, OP_SUB, 32'd10, 32'd3, 2'b11, 1'b0, g);
         check("contention_grant", 128'(g), 128'(cont_exp[k]));
      end
      cycle(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 1'b0, g);

      // Single request: 5 + 7.
      cycle(2'b01, OP_ADD, 32'd5, 32'd7, 0, 0, 0, 2'b11, 1'b0, g);
      check("single_grant", 128'(g), 128'(2'b01));
      cycle(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 1'b0, g);

      // Backpressure on requester 1 with non-owner ready asserted.
      cycle(2'b10, 0, 0, 0, OP_SUB, 32'h8000_0000, 32'd1, 2'b00, 1'b0, g);
      check("bp_grant", 128'(g), 128'(2'b10));
      for (int k = 0; k < 3; k++) begin
         cycle(2'b11, OP_ADD, 32'd1, 32'd1, OP_ADD, 32'd2, 32'd2, 2'b01, 1'b0, g);
         check("bp_hold", 128'(g), 128'd0);
      end
      cycle(2'b11, OP_ADD, 32'd1, 32'd1, OP_ADD, 32'd2, 32'd2, 2'b10, 1'b0, g);
      check("bp_drain_grant", 128'(g), 128'(2'b01));

      // Owner 0 holds the buffer; ready from requester 1 only.
      cycle(2'b10, 0, 0, 0, OP_ADD, 32'd2, 32'd2, 2'b10, 1'b0, g);
      check("nonowner_hold", 128'(g), 128'd0);
      cycle(2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 1'b0, g);

      // Flush while full.
      cycle(2'b01, OP_ADD, 32'd9, 32'd9, 0, 0, 0, 2'b00, 1'b0, g);
      cycle(2'b01, OP_ADD, 32'd9, 32'd9, 0, 0, 0, 2'b00, 1'b1, g);
      check("flush_block", 128'(g), 128'd0);
      cycle(2'b01, OP_ADD, 32'd9, 32'd9, 0, 0, 0, 2'b11, 1'b0, g);
      check("after_flush_grant", 128'(g), 128'(2'b01));
      cycle(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 1'b0, g);

      // Asynchronous reset in the middle of a cycle while full.
      cycle(2'b10, 0, 0, 0, OP_ADD, 32'd3, 32'd4, 2'b00, 1'b0, g);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("async_reset", 128'({rsp_valid, rsp_result, rsp_flags}), 128'd0);
      exp_q.delete();
      model_last = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      #3 reset = 1'b0;
      cycle(2'b11, OP_ADD, 32'd1, 32'd2, OP_ADD, 32'd3, 32'd4, 2'b11, 1'b0, g);
      check("post_reset_first", 128'(g), 128'(2'b01));
      cycle(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 1'b0, g);

      // Randomized traffic; requests are held until accepted.
      pv = 2'b00;
      for (int n = 0; n < 1500; n++) begin
         for (int r = 0; r < 2; r++) begin
            if (!pv[r] && ($urandom_range(0, 2) != 0)) begin
               pv[r] = 1'b1;
               pi[r] = rnd_instr();
               pa[r] = rnd_op();
               pb[r] = rnd_op();
            end
         end
         cycle(pv, pi[0], pa[0], pb[0], pi[1], pa[1], pb[1],
               {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
               ($urandom_range(0, 19) == 0), g);
         pv = pv & ~g;
      end

      cycle(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 1'b0, g);
      cycle(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 1'b0, g);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
